// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the multi-bank word RAM.
// Parity storage is enabled by defining MEMBANK_PARITY_EN.
package mem_bank_pkg;

  typedef enum logic {IDLE, CLEAR} state_e;

  localparam int unsigned DEPTH_DEF = 1024;
  localparam int unsigned OFFW      = $clog2(DEPTH_DEF);

`ifdef MEMBANK_PARITY_EN
  localparam int unsigned PARW = 1;
`else
  localparam int unsigned PARW = 0;
`endif

  function automatic logic [31:0] bank_base(input int unsigned i,
                                            input int unsigned base,
                                            input int unsigned stride);
    return 32'(base + i * stride);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One DEPTH x W synchronous RAM bank: single address, write port and registered read.
module mem_bank #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter int unsigned W     = 32
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bank_array.sv
// Multi-bank word RAM: flat-address decode, registered read/write, miss flag and
// hardware clear sweep. Optional per-word parity under MEMBANK_PARITY_EN.
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int unsigned NBANKS = 2,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 16,
  parameter int unsigned BASE   = 1000,
  parameter int unsigned STRIDE = 2048
) (
  input  logic              iCLOCK,
  input  logic              iRESET,
  input  logic              iREQ,
  input  logic              iWE,
  input  logic [AWIDTH-1:0] iADDR,
  input  logic [DWIDTH-1:0] iWDATA,
  input  logic              iCLEAR,
  input  logic              iPAR_INJ,
  output logic              oREADY,
  output logic              oRVALID,
  output logic [DWIDTH-1:0] oRDATA,
  output logic              oACK,
  output logic              oERR,
  output logic              oPERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WW = DWIDTH + PARW;

  state_e            state_q;
  logic [AW-1:0]     cnt_q;
  logic              rvalid_q, ack_q, err_q;
  logic [NBANKS-1:0] sel_q;

  logic [31:0]       addr_ext;
  logic [NBANKS-1:0] hit;
  logic [AW-1:0]     off      [NBANKS];
  logic              any_hit;
  logic              accept;
  logic [WW-1:0]     wword;

  logic [NBANKS-1:0] bank_we, bank_re;
  logic [AW-1:0]     bank_addr  [NBANKS];
  logic [WW-1:0]     bank_wdata [NBANKS];
  logic [WW-1:0]     bank_rdata [NBANKS];
  logic [WW-1:0]     rword;

  assign addr_ext = 32'(iADDR);

  // Windows are compared in 32 bits so a window crossing the top of the bus never wraps.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      off[i] = AW'(addr_ext - bank_base(i, BASE, STRIDE));
      hit[i] = (addr_ext >= bank_base(i, BASE, STRIDE)) &&
               (addr_ext <  bank_base(i, BASE, STRIDE) + 32'(DEPTH));
    end
  end

  assign any_hit = |hit;
  assign accept  = iREQ && (state_q == IDLE) && !iCLEAR && !iRESET;

`ifdef MEMBANK_PARITY_EN
  assign wword = {(^iWDATA) ^ iPAR_INJ, iWDATA};
`else
  logic unused_par;
  assign unused_par = iPAR_INJ;
  assign wword      = iWDATA;
`endif

  // Clear sweep drives all banks at the counter offset; a reset cycle suppresses that write.
  always_comb begin
    bank_we = '0;
    bank_re = '0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      if (state_q == CLEAR) begin
        bank_we[i]    = !iRESET;
        bank_addr[i]  = cnt_q;
        bank_wdata[i] = '0;
      end else begin
        bank_we[i]    = accept && iWE && hit[i];
        bank_re[i]    = accept && !iWE && hit[i];
        bank_addr[i]  = off[i];
        bank_wdata[i] = wword;
      end
    end
  end

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    mem_bank #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (WW)
    ) u_bank (
      .clk_i   (iCLOCK),
      .we_i    (bank_we[g]),
      .re_i    (bank_re[g]),
      .addr_i  (bank_addr[g]),
      .wdata_i (bank_wdata[g]),
      .rdata_o (bank_rdata[g])
    );
  end

  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      sel_q    <= '0;
    end else begin
      rvalid_q <= accept && !iWE && any_hit;
      ack_q    <= accept && iWE && any_hit;
      err_q    <= accept && !any_hit;
      sel_q    <= (accept && !iWE) ? hit : '0;
      case (state_q)
        IDLE: begin
          if (iCLEAR) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // sel_q is zero unless a read hit last cycle, which also forces oRDATA to 0 on misses.
  always_comb begin
    rword = '0;
    for (int unsigned i = 0; i < NBANKS; i++) begin
      if (sel_q[i]) rword = rword | bank_rdata[i];
    end
  end

  assign oRDATA  = rword[DWIDTH-1:0];
  assign oREADY  = (state_q == IDLE);
  assign oRVALID = rvalid_q;
  assign oACK    = ack_q;
  assign oERR    = err_q;
`ifdef MEMBANK_PARITY_EN
  assign oPERR   = rvalid_q && (^rword);
`else
  assign oPERR   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bank_array.sv
// Directed plus randomized bench for mem_bank_array against an address-level memory model.
module tb_mem_bank_array;

  localparam int NB     = 2;
  localparam int DEPTH  = 1024;
  localparam int BASE   = 1000;
  localparam int STRIDE = 2048;
`ifdef MEMBANK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        iCLOCK = 1'b0;
  logic        iRESET, iREQ, iWE, iCLEAR, iPAR_INJ;
  logic [15:0] iADDR;
  logic [31:0] iWDATA;
  logic        oREADY, oRVALID, oACK, oERR, oPERR;
  logic [31:0] oRDATA;

  int checks = 0;
  int errors = 0;

  bit [31:0] m   [NB][DEPTH];
  bit        bad [NB][DEPTH];

  always #5 iCLOCK = ~iCLOCK;

  mem_bank_array dut (
    .iCLOCK   (iCLOCK),
    .iRESET   (iRESET),
    .iREQ     (iREQ),
    .iWE      (iWE),
    .iADDR    (iADDR),
    .iWDATA   (iWDATA),
    .iCLEAR   (iCLEAR),
    .iPAR_INJ (iPAR_INJ),
    .oREADY   (oREADY),
    .oRVALID  (oRVALID),
    .oRDATA   (oRDATA),
    .oACK     (oACK),
    .oERR     (oERR),
    .oPERR    (oPERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit decode(input int a, output int b, output int o);
    b = 0;
    o = 0;
    if (a < BASE) return 1'b0;
    b = (a - BASE) / STRIDE;
    o = (a - BASE) % STRIDE;
    return (b < NB) && (o < DEPTH);
  endfunction

  // One cycle: present a request (or idle), advance an edge, check the response.
  task automatic step(input string tag, input bit req, input bit we, input int addr,
                      input logic [31:0] data, input bit inj);
    int b, o;
    bit h;
    bit e_rv, e_ack, e_err, e_perr;
    logic [31:0] e_d;
    h      = decode(addr, b, o);
    e_rv   = req && !we && h;
    e_ack  = req && we && h;
    e_err  = req && !h;
    e_d    = e_rv ? m[b][o] : 32'd0;
    e_perr = PAR && e_rv && bad[b][o];
    if (e_ack) begin
      m[b][o]   = data;
      bad[b][o] = PAR && inj;
    end
    iREQ = req; iWE = we; iADDR = 16'(addr); iWDATA = data; iPAR_INJ = inj;
    @(posedge iCLOCK); #1;
    chk({tag, ".rvalid"}, 64'(oRVALID), 64'(e_rv));
    chk({tag, ".rdata"},  64'(oRDATA),  64'(e_d));
    chk({tag, ".ack"},    64'(oACK),    64'(e_ack));
    chk({tag, ".err"},    64'(oERR),    64'(e_err));
    chk({tag, ".perr"},   64'(oPERR),   64'(e_perr));
    chk({tag, ".ready"},  64'(oREADY),  64'd1);
  endtask

  task automatic idle();
    iREQ = 1'b0; iWE = 1'b0; iCLEAR = 1'b0; iPAR_INJ = 1'b0;
  endtask

  // Full sweep; optionally presents a same-cycle write that must be dropped.
  task automatic full_clear(input string tag, input bit with_req);
    int n;
    iCLEAR = 1'b1; iREQ = with_req; iWE = 1'b1; iADDR = 16'd1000; iWDATA = 32'hFFFF_FFFF;
    @(posedge iCLOCK); #1;
    idle();
    chk({tag, ".noack"}, 64'(oACK), 64'd0);
    n = 0;
    while (oREADY === 1'b0 && n < 3000) begin
      n++;
      if (n < 500) begin iREQ = 1'b1; iCLEAR = 1'b1; iWE = 1'b1; end
      else idle();
      if (n == 600) chk({tag, ".quiet"}, 64'({oRVALID, oACK, oERR}), 64'd0);
      @(posedge iCLOCK); #1;
    end
    chk({tag, ".len"}, 64'(n), 64'(DEPTH));
    for (int b = 0; b < NB; b++)
      for (int o = 0; o < DEPTH; o++) begin m[b][o] = '0; bad[b][o] = 1'b0; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int a, sel;
    iRESET = 1'b1; idle(); iADDR = '0; iWDATA = '0;
    repeat (2) @(posedge iCLOCK);
    #1;
    chk("rst.ready",  64'(oREADY),  64'd1);
    chk("rst.pulses", 64'({oRVALID, oACK, oERR, oPERR}), 64'd0);
    chk("rst.rdata",  64'(oRDATA),  64'd0);
    iRESET = 1'b0;

    full_clear("init", 1'b0);

    step("t1.wr", 1, 1, 1000, 32'hDEAD_BEEF, 0);
    step("t1.rd", 1, 0, 1000, '0, 0);
    step("t1.idle", 0, 0, 1000, '0, 0);

    step("t2.wr", 1, 1, 4071, 32'h1234_5678, 0);
    step("t2.rd", 1, 0, 4071, '0, 0);
    step("t2.miss", 1, 0, 2024, '0, 0);
    step("t2.lo", 1, 0, 999, '0, 0);
    step("t2.hi", 1, 0, 4072, '0, 0);
    step("t2.b0end", 1, 1, 2023, 32'h0BAD_F00D, 0);

    step("t3.w0", 1, 1, 1000, 32'd1, 0);
    step("t3.w1", 1, 1, 1001, 32'd2, 0);
    step("t3.w2", 1, 1, 1002, 32'd3, 0);
    step("t3.r0", 1, 0, 1000, '0, 0);
    step("t3.r1", 1, 0, 1001, '0, 0);
    step("t3.r2", 1, 0, 1002, '0, 0);
    step("t3.idle", 0, 0, 0, '0, 0);

    full_clear("t4", 1'b1);
    step("t4.rd0", 1, 0, 1000, '0, 0);
    step("t4.rd1", 1, 0, 4071, '0, 0);

    step("t5.w5", 1, 1, 1005, 32'h5555_0005, 0);
    step("t5.w10", 1, 1, 1010, 32'hAAAA_0010, 0);
    step("t5.w9", 1, 1, 3057, 32'h9999_0009, 0);
    idle();
    iCLEAR = 1'b1;
    @(posedge iCLOCK); #1;
    iCLEAR = 1'b0;
    repeat (9) @(posedge iCLOCK);
    #1;
    chk("t5.busy", 64'(oREADY), 64'd0);
    iRESET = 1'b1;
    @(posedge iCLOCK); #1;
    iRESET = 1'b0;
    chk("t5.ready",  64'(oREADY), 64'd1);
    chk("t5.pulses", 64'({oRVALID, oACK, oERR, oPERR}), 64'd0);
    for (int b = 0; b < NB; b++)
      for (int o = 0; o < 9; o++) begin m[b][o] = '0; bad[b][o] = 1'b0; end
    step("t5.rd5", 1, 0, 1005, '0, 0);
    step("t5.rd10", 1, 0, 1010, '0, 0);
    step("t5.rd9b1", 1, 0, 3057, '0, 0);

    step("t6.winj", 1, 1, 1005, 32'hA5, 1);
    step("t6.rinj", 1, 0, 1005, '0, 0);
    step("t6.wok", 1, 1, 1005, 32'hA5, 0);
    step("t6.rok", 1, 0, 1005, '0, 0);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = BASE + int'($urandom_range(0, DEPTH - 1));
        1: a = BASE + STRIDE + int'($urandom_range(0, DEPTH - 1));
        2: a = ($urandom_range(0, 1) != 0) ? BASE - 1 : BASE + DEPTH;
        3: a = ($urandom_range(0, 1) != 0) ? BASE + STRIDE + DEPTH - 1 : BASE + STRIDE;
        4: a = int'($urandom_range(0, 65535));
        default: a = BASE + DEPTH - 1;
      endcase
      step("rnd", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) != 0, a,
           32'($urandom), $urandom_range(0, 1) != 0);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
